// File: rtl/simd_pe_array.sv
// simd_pe_array: N-lane elementwise ALU, pipelined adder tree and multi-beat dot-product accumulator.
// Build option: define SIMD_PE_SAT_EN to saturate the accumulator add instead of wrapping.

module simd_pe_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int OPCODE_LEN = 4
) (
    input  logic [OPCODE_LEN-1:0] op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);
    always_comb begin
        res_o = '0;
        case (op_i)
            OPCODE_LEN'(1):                 res_o = a_i + b_i;
            OPCODE_LEN'(2):                 res_o = a_i - b_i;
            OPCODE_LEN'(3), OPCODE_LEN'(4): res_o = a_i * b_i;
            default:                        res_o = '0;
        endcase
    end
endmodule

module simd_pe_array #(
    parameter int PE_ELEMENTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 32,
    parameter int OPCODE_LEN  = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [OPCODE_LEN-1:0]             in_opcode,
    input  logic                              in_first,
    input  logic                              in_last,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] in_a,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] in_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_is_scalar,
    output logic [PE_ELEMENTS*DATA_WIDTH-1:0] out_vec,
    output logic [ACC_WIDTH-1:0]              out_scalar,
    output logic                              err_illegal
);
    localparam int N     = PE_ELEMENTS;
    localparam int LOG2N = $clog2(PE_ELEMENTS);

    localparam logic [OPCODE_LEN-1:0] OP_ADD  = OPCODE_LEN'(1);
    localparam logic [OPCODE_LEN-1:0] OP_SUB  = OPCODE_LEN'(2);
    localparam logic [OPCODE_LEN-1:0] OP_MUL  = OPCODE_LEN'(3);
    localparam logic [OPCODE_LEN-1:0] OP_DOTP = OPCODE_LEN'(4);
    localparam logic [OPCODE_LEN-1:0] OP_LAST = OPCODE_LEN'(4);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic is_dotp;
        logic first;
        logic last;
    } meta_t;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    typedef logic [N-1:0][ACC_WIDTH-1:0]  sum_t;

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
`ifdef SIMD_PE_SAT_EN
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    logic adv, accept, op_ew, op_dotp, op_ill, s0_vld_d;
    vec_t a_lanes, b_lanes, lane_res;

    // Global stall: every stage moves only when the output register can move.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;
    assign op_ew    = (in_opcode == OP_ADD) | (in_opcode == OP_SUB) | (in_opcode == OP_MUL);
    assign op_dotp  = (in_opcode == OP_DOTP);
    assign op_ill   = (in_opcode > OP_LAST);
    assign s0_vld_d = accept & (op_ew | op_dotp);
    assign a_lanes  = in_a;
    assign b_lanes  = in_b;

    for (genvar i = 0; i < N; i++) begin : g_lane
        simd_pe_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .OPCODE_LEN(OPCODE_LEN)
        ) u_lane (
            .op_i (in_opcode),
            .a_i  (a_lanes[i]),
            .b_i  (b_lanes[i]),
            .res_o(lane_res[i])
        );
    end

    logic [LOG2N:0] vld_pipe_q;
    meta_t          meta_q [0:LOG2N];
    vec_t           vec_q  [0:LOG2N];
    sum_t           sum_q  [1:LOG2N];
    sum_t           lvl    [0:LOG2N];
    sum_t           tree_d [1:LOG2N];
    logic           err_q;

    // Level 0 of the tree is the S0 lane result viewed as a sign-extended product.
    for (genvar i = 0; i < N; i++) begin : g_ext
        assign lvl[0][i] = ACC_WIDTH'($signed(vec_q[0][i]));
    end

    for (genvar l = 1; l <= LOG2N; l++) begin : g_lvl
        assign lvl[l] = sum_q[l];
        for (genvar i = 0; i < N; i++) begin : g_node
            if (i < (N >> l)) begin : g_add
                assign tree_d[l][i] = lvl[l-1][2*i] + lvl[l-1][2*i+1];
            end else begin : g_zero
                assign tree_d[l][i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k <= LOG2N; k++) begin
                meta_q[k] <= '0;
                vec_q[k]  <= '0;
            end
            for (int k = 1; k <= LOG2N; k++) sum_q[k] <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[LOG2N-1:0], s0_vld_d};
            meta_q[0]  <= '{is_dotp: op_dotp, first: in_first, last: in_last};
            vec_q[0]   <= lane_res;
            for (int k = 1; k <= LOG2N; k++) begin
                meta_q[k] <= meta_q[k-1];
                vec_q[k]  <= vec_q[k-1];
                sum_q[k]  <= tree_d[k];
            end
            if (accept && op_ill) err_q <= 1'b1;
        end
    end

    logic                 out_valid_q, out_is_scalar_q;
    logic                 out_valid_d, out_is_scalar_d;
    vec_t                 out_vec_q, out_vec_d;
    logic [ACC_WIDTH-1:0] out_scalar_q, out_scalar_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_new, treesum;
    meta_t                sa_meta;

    assign sa_meta = meta_q[LOG2N];
    assign treesum = sum_q[LOG2N][0];
    assign acc_new = sa_meta.first ? treesum : acc_add(acc_q, treesum);

    always_comb begin
        out_valid_d     = 1'b0;
        out_is_scalar_d = out_is_scalar_q;
        out_vec_d       = out_vec_q;
        out_scalar_d    = out_scalar_q;
        acc_d           = acc_q;
        if (vld_pipe_q[LOG2N]) begin
            if (!sa_meta.is_dotp) begin
                out_valid_d     = 1'b1;
                out_is_scalar_d = 1'b0;
                out_vec_d       = vec_q[LOG2N];
                out_scalar_d    = '0;
            end else if (sa_meta.last) begin
                out_valid_d     = 1'b1;
                out_is_scalar_d = 1'b1;
                out_vec_d       = '0;
                out_scalar_d    = acc_new;
                acc_d           = '0;
            end else begin
                acc_d = acc_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q     <= 1'b0;
            out_is_scalar_q <= 1'b0;
            out_vec_q       <= '0;
            out_scalar_q    <= '0;
            acc_q           <= '0;
        end else if (adv) begin
            out_valid_q     <= out_valid_d;
            out_is_scalar_q <= out_is_scalar_d;
            out_vec_q       <= out_vec_d;
            out_scalar_q    <= out_scalar_d;
            acc_q           <= acc_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_is_scalar = out_is_scalar_q;
    assign out_vec       = out_vec_q;
    assign out_scalar    = out_scalar_q;
    assign err_illegal   = err_q;

endmodule

// File: tb/tb_simd_pe_array.sv
// Self-checking bench for simd_pe_array: directed scenarios plus a randomized stream vs a lane/accumulator model.
module tb_simd_pe_array;
    localparam int N = 4, DW = 32, AW = 32, OPL = 4, LOG2N = 2;
    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct { bit sc; vec_t v; logic [AW-1:0] s; } out_t;

    logic           clk, rstn, in_valid, in_ready, in_first, in_last;
    logic [OPL-1:0] in_opcode;
    logic [N*DW-1:0] in_a, in_b, out_vec;
    logic           out_valid, out_ready, out_is_scalar, err_illegal;
    logic [AW-1:0]  out_scalar;

    out_t   exp_q[$], obs_q[$];
    longint acc_m;
    bit     err_m, bp_on;
    int     checks, failures;

    simd_pe_array #(.PE_ELEMENTS(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OPCODE_LEN(OPL)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_is_scalar(out_is_scalar), .out_vec(out_vec),
        .out_scalar(out_scalar), .err_illegal(err_illegal));

    initial begin clk = 0; forever #5 clk = ~clk; end

    // Record every completed output handshake; the edge that follows performs the transfer.
    always @(negedge clk) begin
        out_t o;
        if (rstn && out_valid && out_ready) begin
            o.sc = out_is_scalar; o.v = out_vec; o.s = out_scalar;
            obs_q.push_back(o);
        end
    end

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        return v;
    endfunction

    function automatic vec_t fill(input int x);
        return mk(x, x, x, x);
    endfunction

    function automatic longint wrap_acc(input longint x);
        return (x <<< (64 - AW)) >>> (64 - AW);
    endfunction

    function automatic longint acc_sum(input longint a, input longint b);
        longint s, hi, lo;
        s  = a + b;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -(longint'(1) <<< (AW - 1));
`ifdef SIMD_PE_SAT_EN
        return (s > hi) ? hi : (s < lo) ? lo : s;
`else
        if (hi < lo) return 0;
        return wrap_acc(s);
`endif
    endfunction

    // Reference model: what each accepted beat should eventually produce.
    function automatic void model_beat(input int op, input bit f, input bit l, input vec_t a, input vec_t b);
        out_t e;
        vec_t r;
        longint ts, nacc;
        logic [DW-1:0] p;
        if (op >= 5) err_m = 1;
        if (op >= 1 && op <= 3) begin
            for (int i = 0; i < N; i++)
                r[i] = (op == 1) ? a[i] + b[i] : (op == 2) ? a[i] - b[i] : a[i] * b[i];
            e.sc = 0; e.v = r; e.s = '0;
            exp_q.push_back(e);
        end else if (op == 4) begin
            ts = 0;
            for (int i = 0; i < N; i++) begin
                p = a[i] * b[i];
                ts += longint'($signed(p));
            end
            ts = wrap_acc(ts);
            nacc = f ? ts : acc_sum(acc_m, ts);
            if (l) begin
                e.sc = 1; e.v = '0; e.s = nacc[AW-1:0];
                exp_q.push_back(e);
                acc_m = 0;
            end else acc_m = nacc;
        end
    endfunction

    task automatic send(input int op, input bit f, input bit l, input vec_t a, input vec_t b);
        int n;
        n = 0;
        in_valid = 1; in_opcode = op[OPL-1:0]; in_first = f; in_last = l; in_a = a; in_b = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(posedge clk); #1; @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_accept_timeout op=%0d got in_ready=%0b exp=1", op, in_ready);
        end else model_beat(op, f, l, a, b);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 300) begin @(posedge clk); #1; n++; end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_is_scalar !== 1'b0) begin failures++; $display("FAIL rst_is_scalar got=%0b exp=0", out_is_scalar); end
        checks++; if (out_vec !== '0) begin failures++; $display("FAIL rst_out_vec got=%0h exp=0", out_vec); end
        checks++; if (out_scalar !== '0) begin failures++; $display("FAIL rst_out_scalar got=%0h exp=0", out_scalar); end
        checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_illegal); end
    endtask

    task automatic test_add_sub();
        int n;
        clear_q();
        send(1, 0, 0, mk(1, 2, 3, 4), mk(10, 20, 30, 40));
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n != LOG2N + 2) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", n, LOG2N + 2); end
        checks++; if (out_vec !== mk(11, 22, 33, 44)) begin failures++; $display("FAIL add_vec got=%0h exp=%0h", out_vec, mk(11, 22, 33, 44)); end
        checks++; if (out_is_scalar !== 1'b0) begin failures++; $display("FAIL add_is_scalar got=%0b exp=0", out_is_scalar); end
        checks++; if (out_scalar !== '0) begin failures++; $display("FAIL add_scalar got=%0h exp=0", out_scalar); end
        send(2, 0, 0, mk(1, 2, 3, 4), mk(10, 20, 30, 40));
        drain();
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL addsub_count got=%0d exp=2", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[1].v !== mk(-9, -18, -27, -36) || obs_q[1].sc !== 1'b0) begin
                failures++; $display("FAIL sub_vec got=%0h exp=%0h", obs_q[1].v, mk(-9, -18, -27, -36));
            end
        end
    endtask

    task automatic test_dotp_mul();
        clear_q();
        send(4, 1, 1, mk(1, 2, 3, 4), mk(5, 6, 7, 8));
        send(3, 0, 0, mk(32'h10000, 3, -2, 7), mk(32'h10000, 5, 4, -1));
        drain();
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL dotp_count got=%0d exp=2", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0].sc !== 1'b1 || obs_q[0].s !== 32'd70) begin
                failures++; $display("FAIL dotp_70 got=%0d sc=%0b exp=70 sc=1", obs_q[0].s, obs_q[0].sc);
            end
            checks++;
            if (obs_q[1].sc !== 1'b0 || obs_q[1].v !== mk(0, 15, -8, -7)) begin
                failures++; $display("FAIL mul_vec got=%0h exp=%0h", obs_q[1].v, mk(0, 15, -8, -7));
            end
        end
    endtask

    task automatic test_interleave();
        clear_q();
        send(4, 1, 0, fill(1), fill(1));
        send(1, 0, 0, mk(5, 6, 7, 8), fill(1));
        send(4, 0, 0, fill(1), fill(1));
        send(4, 0, 1, fill(1), fill(1));
        drain();
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL ilv_count got=%0d exp=2", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0].sc !== 1'b0 || obs_q[0].v !== mk(6, 7, 8, 9)) begin
                failures++; $display("FAIL ilv_add got=%0h exp=%0h", obs_q[0].v, mk(6, 7, 8, 9));
            end
            checks++;
            if (obs_q[1].sc !== 1'b1 || obs_q[1].s !== 32'd12) begin
                failures++; $display("FAIL ilv_dotp got=%0d exp=12", obs_q[1].s);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t held;
        int   n;
        clear_q();
        fork
            begin
                for (int i = 0; i < 6; i++) send(1, 0, 0, fill(i), fill(100));
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
                out_ready = 0;
                held = out_vec;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_vec !== held || out_valid !== 1'b1) begin
                        failures++; $display("FAIL stall_hold c=%0d got=%0h exp=%0h", c, out_vec, held);
                    end
                    checks++;
                    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready c=%0d got=%0b exp=0", c, in_ready); end
                end
                out_ready = 1;
            end
        join
        drain();
        checks++; if (obs_q.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", obs_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_q[i].v !== fill(100 + i)) begin
                failures++; $display("FAIL b2b_order i=%0d got=%0h exp=%0h", i, obs_q[i].v, fill(100 + i));
            end
        end
    endtask

    task automatic test_sat();
        logic [AW-1:0] exp_s;
`ifdef SIMD_PE_SAT_EN
        exp_s = 32'h7FFFFFFF;
`else
        exp_s = 32'h80000000;
`endif
        clear_q();
        send(4, 1, 0, fill(32'h10000000), fill(1));
        send(4, 0, 1, fill(32'h10000000), fill(1));
        drain();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL sat_count got=%0d exp=1", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0].s !== exp_s) begin failures++; $display("FAIL sat_scalar got=%0h exp=%0h", obs_q[0].s, exp_s); end
        end
    endtask

    task automatic test_random();
        int ops[8] = '{0, 1, 2, 3, 4, 4, 4, 9};
        int op;
        bit f, l;
        vec_t a, b;
        clear_q();
        bp_on = 1;
        fork
            while (bp_on) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
        join_none
        for (int k = 0; k < 80; k++) begin
            op = ops[$urandom_range(0, 7)];
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                a[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 200) - 100;
                b[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 200) - 100;
            end
            send(op, f, l, a, b);
        end
        bp_on = 0;
        @(posedge clk); #2;
        out_ready = 1;
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].sc !== exp_q[i].sc || (exp_q[i].sc ? obs_q[i].s !== exp_q[i].s : obs_q[i].v !== exp_q[i].v)) begin
                failures++;
                $display("FAIL rnd_out i=%0d got sc=%0b v=%0h s=%0h exp sc=%0b v=%0h s=%0h", i,
                         obs_q[i].sc, obs_q[i].v, obs_q[i].s, exp_q[i].sc, exp_q[i].v, exp_q[i].s);
            end
        end
        checks++; if (err_illegal !== err_m) begin failures++; $display("FAIL rnd_err got=%0b exp=%0b", err_illegal, err_m); end
    endtask

    task automatic test_illegal_reset();
        clear_q();
        send(9, 0, 0, fill(3), fill(4));
        repeat (8) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL ill_output got=%0d exp=0", obs_q.size()); end
        checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL ill_err got=%0b exp=1", err_illegal); end
        in_valid = 1; in_opcode = 4; in_first = 1; in_last = 0; in_a = fill(7); in_b = fill(7);
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rstn = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_is_scalar !== 1'b0 || out_vec !== '0 || out_scalar !== '0) begin
            failures++; $display("FAIL mrst_outputs got sc=%0b v=%0h s=%0h exp=0", out_is_scalar, out_vec, out_scalar);
        end
        checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL mrst_err got=%0b exp=0", err_illegal); end
        acc_m = 0; err_m = 0;
        clear_q();
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        send(4, 0, 1, fill(1), fill(2));
        drain();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL post_rst_count got=%0d exp=1", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0].sc !== 1'b1 || obs_q[0].s !== 32'd8) begin
                failures++; $display("FAIL post_rst_dotp got=%0d exp=8", obs_q[0].s);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; acc_m = 0; err_m = 0; bp_on = 0;
        rstn = 0; in_valid = 0; in_opcode = '0; in_first = 0; in_last = 0;
        in_a = '0; in_b = '0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1;
        @(posedge clk); #1;
        test_add_sub();
        test_dotp_mul();
        test_interleave();
        test_back_to_back();
        test_sat();
        test_random();
        test_illegal_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
